// File: rtl/slt_seq_unit_pkg.sv
// rtl/slt_seq_unit_pkg.sv - shared state encodings and helpers for the multi-cycle SLT unit
// Purpose: FSM state type (IDLE=0, CMP=1, DONE=2) and the chunk-count helper.
// Ports: none (package).
package slt_seq_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } slt_state_t;

    function automatic int slt_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/slt_seq_unit_if.sv
// rtl/slt_seq_unit_if.sv - operand/result handshake bundle for slt_seq_unit
// Purpose: groups the request (in_*) and response (out_*) handshakes.
// Ports (signals): in_valid/in_ready/a/b/is_signed request side,
//                  out_valid/out_ready/result/out_eq response side.
// Modports: slave = the unit, master = producer/consumer.
interface slt_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             out_eq;

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, result, out_eq
    );

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, result, out_eq
    );
endinterface

// File: rtl/slt_seq_unit_chunk_cmp.sv
// rtl/slt_seq_unit_chunk_cmp.sv - combinational unsigned compare of one operand chunk
// Purpose: lt/eq of two CHUNK-bit slices; flip_msb inverts the MSB of both
//          slices so the top chunk of a signed compare orders correctly.
// Ports: ca, cb (chunk slices), flip_msb (signed top chunk), lt, eq.
module chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] ca,
    input  logic [CHUNK-1:0] cb,
    input  logic             flip_msb,
    output logic             lt,
    output logic             eq
);
    logic [CHUNK-1:0] w_mask;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;

    always_comb begin
        w_mask            = '0;
        w_mask[CHUNK-1]   = flip_msb;
    end

    // Inverting the sign bit on both sides maps two's complement onto unsigned order.
    assign w_ca = ca ^ w_mask;
    assign w_cb = cb ^ w_mask;
    assign lt   = (w_ca < w_cb);
    assign eq   = (w_ca == w_cb);
endmodule

// File: rtl/slt_seq_unit.sv
// rtl/slt_seq_unit.sv - multi-cycle SLT/SLTU unit, CHUNK bits per cycle from the MSB chunk
// Purpose: result = {WIDTH-1 zeros, a < b} (signed or unsigned), out_eq = (a == b).
// Ports: clk, rst_n (async active-low), bus (slt_seq_unit_if.slave).
// Build option: SLT_EARLY_EXIT_EN - leave CMP at the first differing chunk.
module slt_seq_unit
    import slt_seq_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    slt_seq_unit_if.slave  bus
);
    localparam int NCHUNK = slt_nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = $clog2(NCHUNK) + 1;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("slt_seq_unit: WIDTH must be a multiple of CHUNK");
    end

    slt_state_t       r_state;
    slt_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lt;
    logic             r_decided;
    logic             r_out_valid;

    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_flip;
    logic             w_lt;
    logic             w_eq;
    logic             w_last;

    always_comb begin
        w_ca = '0;
        w_cb = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_ca = r_a[i*CHUNK +: CHUNK];
                w_cb = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    assign w_flip = r_signed && (r_cnt == CNT_W'(NCHUNK - 1));

    chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
        .ca       (w_ca),
        .cb       (w_cb),
        .flip_msb (w_flip),
        .lt       (w_lt),
        .eq       (w_eq)
    );

`ifdef SLT_EARLY_EXIT_EN
    assign w_last = (r_cnt == '0) || (!r_decided && !w_eq);
`else
    assign w_last = (r_cnt == '0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)                    w_state_nxt = ST_CMP;
            ST_CMP:  if (w_last)                          w_state_nxt = ST_DONE;
            ST_DONE: if (r_out_valid && bus.out_ready)    w_state_nxt = ST_IDLE;
            default:                                      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_signed    <= 1'b0;
            r_cnt       <= '0;
            r_lt        <= 1'b0;
            r_decided   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a       <= bus.a;
                        r_b       <= bus.b;
                        r_signed  <= bus.is_signed;
                        r_cnt     <= CNT_W'(NCHUNK - 1);
                        r_lt      <= 1'b0;
                        r_decided <= 1'b0;
                    end
                end
                ST_CMP: begin
                    // Only the most significant differing chunk decides the order.
                    if (!r_decided && !w_eq) begin
                        r_lt      <= w_lt;
                        r_decided <= 1'b1;
                    end
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_DONE: begin
                    // First DONE cycle registers out_valid; it drops on the accepting edge.
                    r_out_valid <= !(r_out_valid && bus.out_ready);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_out_valid ? {{(WIDTH-1){1'b0}}, r_lt} : '0;
    assign bus.out_eq    = r_out_valid && !r_decided;
endmodule

// File: tb/tb_slt_seq_unit.sv
// tb/tb_slt_seq_unit.sv - self-checking bench for slt_seq_unit (vector table + scoreboard)
module tb_slt_seq_unit;
    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slt_seq_unit_if #(.WIDTH(WIDTH)) bus ();

    slt_seq_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        lt;
        logic        eq;
    } vec_t;

    typedef struct {
        logic lt;
        logic eq;
        int   lat;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef SLT_EARLY_EXIT_EN
        logic [31:0] d;
        d = a ^ b;
        for (int i = NCHUNK - 1; i >= 0; i--)
            if (d[i*CHUNK +: CHUNK] != '0) return (NCHUNK - i) + 1;
        return NCHUNK + 1;
`else
        return NCHUNK + 1;
`endif
    endfunction

    // Drive a request, wait for acceptance, push expected, then disturb the inputs.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic lt, input logic eq);
        int t;
        exp_t e;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.is_signed = sgn; bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_at_accept", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        e.lt = lt; e.eq = eq; e.lat = exp_latency(a, b);
        sb.push_back(e);
        #1;
        bus.in_valid = 1'b0;
        bus.a = ~a; bus.b = ~b; bus.is_signed = ~sgn;
    endtask

    // Wait for out_valid, compare against the scoreboard, optionally stall, then accept.
    task automatic collect(input int hold);
        int   lat;
        exp_t e;
        logic [31:0] res0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid_seen", {31'b0, bus.out_valid}, 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
            e.lt = 1'b0; e.eq = 1'b0; e.lat = 0;
        end else begin
            e = sb.pop_front();
        end
        check("latency", lat, e.lat);
        check("result", bus.result, {31'b0, e.lt});
        check("out_eq", {31'b0, bus.out_eq}, {31'b0, e.eq});
        res0 = bus.result;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.a = $urandom; bus.b = $urandom;
            @(posedge clk);
            #1;
            check("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("hold_result", bus.result, res0);
            check("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("out_valid_fall", {31'b0, bus.out_valid}, 32'd0);
        check("in_ready_after", {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs, rlt;

        vecs[0]  = '{32'h0000_0007, 32'h0000_0006, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFF9, 32'h0000_0006, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{32'hFFFF_FFF9, 32'h0000_0006, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{32'hFFFF_FFFA, 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{32'h0000_0008, 32'h0000_0030, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0; bus.out_ready = 1'b0;

        #1;
        check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_result",    bus.result,             32'd0);
        check("rst_out_eq",    {31'b0, bus.out_eq},    32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].lt, vecs[i].eq);
            collect(0);
        end

        // Consumer stall in DONE with ignored in_valid pulses, then a normal follow-up.
        send(32'h0000_0005, 32'h0000_0009, 1'b0, 1'b1, 1'b0);
        collect(10);
        send(32'h1234_5678, 32'h1234_5677, 1'b0, 1'b0, 1'b0);
        collect(0);

        // Reset during CMP: outputs return to reset values without a clock edge.
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_result",    bus.result,             32'd0);
        check("midrst_out_eq",    {31'b0, bus.out_eq},    32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("no_stale_out_valid", {31'b0, bus.out_valid}, 32'd0);
        end
        send(32'h0000_0006, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
        collect(0);

        // Random operands, including equal pairs and single-bit differences.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case (i % 4)
                0:       rb = ra;
                1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = $urandom;
            endcase
            rs  = i[1];
            rlt = rs ? ($signed(ra) < $signed(rb)) : (ra < rb);
            send(ra, rb, rs, rlt, ra == rb);
            collect(i % 3);
        end

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
